// File: rtl/input_conditioner.sv
// Pushbutton and switch front end for the multiplier: synchronizes, debounces and
// interlocks the Run / ClearA_LoadB keys, and snapshots the switch bank on each accepted press.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run_raw,
    input  logic       ClearA_LoadB_raw,
    input  logic [7:0] S_raw,
    output logic       Run,
    output logic       ClearA_LoadB,
    output logic       Run_press,
    output logic       Clr_press,
    output logic [7:0] S,
    output logic [7:0] S_snap,
    output logic [7:0] Run_count
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_t;

    typedef struct packed {
        db_state_t        st;
        logic [CNT_W-1:0] cnt;
    } db_t;

    // The wait states move on once the count reaches DEBOUNCE_CYCLES-1, so the
    // transition is taken from the cycle holding DEBOUNCE_CYCLES-2.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

    function automatic db_t db_step(input db_t cur, input logic sync_in);
        db_t nx;
        nx = cur;
        case (cur.st)
            IDLE: begin
                nx.cnt = '0;
                if (!sync_in) begin
                    nx.st = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (sync_in) begin
                    nx.st  = IDLE;
                    nx.cnt = '0;
                end else if (cur.cnt == CNT_LAST) begin
                    nx.st  = PRESSED;
                    nx.cnt = '0;
                end else begin
                    nx.cnt = cur.cnt + 1'b1;
                end
            end
            PRESSED: begin
                nx.cnt = '0;
                if (sync_in) begin
                    nx.st = RELEASE_WAIT;
                end
            end
            RELEASE_WAIT: begin
                if (!sync_in) begin
                    nx.st  = PRESSED;
                    nx.cnt = '0;
                end else if (cur.cnt == CNT_LAST) begin
                    nx.st  = IDLE;
                    nx.cnt = '0;
                end else begin
                    nx.cnt = cur.cnt + 1'b1;
                end
            end
            default: begin
                nx.st  = IDLE;
                nx.cnt = '0;
            end
        endcase
        return nx;
    endfunction

    // Active-low level: low while the key is considered held down.
    function automatic logic db_level(input db_state_t st);
        return !((st == PRESSED) || (st == RELEASE_WAIT));
    endfunction

    logic       run_sync_p0, run_sync_p1;
    logic       clr_sync_p0, clr_sync_p1;
    logic [7:0] s_sync_p0;

    db_t  run_db, run_nx;
    db_t  clr_db, clr_nx;
    logic run_enter, clr_enter, run_block;

    // Stage p0/p1: two-flop synchronizers; keys idle released, switches idle low
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            run_sync_p0 <= 1'b1;
            run_sync_p1 <= 1'b1;
            clr_sync_p0 <= 1'b1;
            clr_sync_p1 <= 1'b1;
            s_sync_p0   <= 8'h00;
            S           <= 8'h00;
        end else begin
            run_sync_p0 <= Run_raw;
            run_sync_p1 <= run_sync_p0;
            clr_sync_p0 <= ClearA_LoadB_raw;
            clr_sync_p1 <= clr_sync_p0;
            s_sync_p0   <= S_raw;
            S           <= s_sync_p0;
        end
    end

    // ClearA_LoadB has priority: an accepted clear freezes any Run press that has
    // not yet been accepted, and wins a same-edge acceptance race outright.
    always_comb begin
        clr_nx    = db_step(clr_db, clr_sync_p1);
        run_nx    = db_step(run_db, run_sync_p1);
        clr_enter = (clr_db.st == PRESS_WAIT) && (clr_nx.st == PRESSED);
        run_enter = (run_db.st == PRESS_WAIT) && (run_nx.st == PRESSED);
        run_block = (!ClearA_LoadB && ((run_db.st == IDLE) || (run_db.st == PRESS_WAIT)))
                  || (run_enter && clr_enter);
        if (run_block) begin
            run_nx.st  = IDLE;
            run_nx.cnt = '0;
            run_enter  = 1'b0;
        end
    end

    // Stage debounce: FSM state plus registered levels, pulses and snapshot
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            run_db.st    <= IDLE;
            run_db.cnt   <= '0;
            clr_db.st    <= IDLE;
            clr_db.cnt   <= '0;
            Run          <= 1'b1;
            ClearA_LoadB <= 1'b1;
            Run_press    <= 1'b0;
            Clr_press    <= 1'b0;
            S_snap       <= 8'h00;
        end else begin
            run_db       <= run_nx;
            clr_db       <= clr_nx;
            Run          <= db_level(run_nx.st);
            ClearA_LoadB <= db_level(clr_nx.st);
            Run_press    <= run_enter;
            Clr_press    <= clr_enter;
            if (run_enter || clr_enter) begin
                S_snap <= S;
            end
        end
    end

    // Stage count: clear beats increment if both pulses ever coincide
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Run_count <= 8'h00;
        end else if (Clr_press) begin
            Run_count <= 8'h00;
        end else if (Run_press) begin
            Run_count <= Run_count + 8'h01;
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: expected press events are queued by the
// stimulus and matched by a monitor against every observed press pulse.
module tb_input_conditioner;

    localparam int D = 4;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Run_raw;
    logic       ClearA_LoadB_raw;
    logic [7:0] S_raw;
    logic       Run;
    logic       ClearA_LoadB;
    logic       Run_press;
    logic       Clr_press;
    logic [7:0] S;
    logic [7:0] S_snap;
    logic [7:0] Run_count;

    input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .Run_raw          (Run_raw),
        .ClearA_LoadB_raw (ClearA_LoadB_raw),
        .S_raw            (S_raw),
        .Run              (Run),
        .ClearA_LoadB     (ClearA_LoadB),
        .Run_press        (Run_press),
        .Clr_press        (Clr_press),
        .S                (S),
        .S_snap           (S_snap),
        .Run_count        (Run_count)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_clr;
        int         at_cyc;
        logic [7:0] snap;
    } ev_t;

    ev_t sb_q[$];
    int  n_checks = 0;
    int  n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // A key first sampled low at edge k yields its pulse just after edge k+1+D.
    task automatic expect_press(input bit is_clr, input int k, input logic [7:0] snap);
        ev_t e;
        e.is_clr = is_clr;
        e.at_cyc = k + 1 + D;
        e.snap   = snap;
        sb_q.push_back(e);
    endtask

    task automatic check_pulse(input bit is_clr);
        ev_t e;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_press: got %s pulse at cycle %0d, required none",
                     is_clr ? "Clr" : "Run", cyc);
            return;
        end
        e = sb_q.pop_front();
        if (e.is_clr != is_clr || e.at_cyc != cyc || e.snap !== S_snap) begin
            n_err++;
            $display("FAIL press_event: got clr=%0d cyc=%0d snap=%h, required clr=%0d cyc=%0d snap=%h",
                     is_clr, cyc, S_snap, e.is_clr, e.at_cyc, e.snap);
        end
    endtask

    always @(negedge Clk) begin
        if (Run_press) check_pulse(1'b0);
        if (Clr_press) check_pulse(1'b1);
    end

    task automatic press_key(input bit is_clr, input int hold, input bit pulse,
                             input logic [7:0] snap);
        int k;
        @(negedge Clk);
        if (is_clr) ClearA_LoadB_raw = 1'b0;
        else        Run_raw          = 1'b0;
        k = cyc + 1;
        if (pulse) expect_press(is_clr, k, snap);
        repeat (hold) @(negedge Clk);
        if (is_clr) ClearA_LoadB_raw = 1'b1;
        else        Run_raw          = 1'b1;
        repeat (D + 6) @(negedge Clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_run"},       Run,          1);
        chk({tag, "_clr"},       ClearA_LoadB, 1);
        chk({tag, "_run_press"}, Run_press,    0);
        chk({tag, "_clr_press"}, Clr_press,    0);
        chk({tag, "_s"},         S,            8'h00);
        chk({tag, "_s_snap"},    S_snap,       8'h00);
        chk({tag, "_run_count"}, Run_count,    8'h00);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k;
        int  r;
        bit  run_seen_low;

        Reset            = 1'b0;
        Run_raw          = 1'b1;
        ClearA_LoadB_raw = 1'b1;
        S_raw            = 8'h00;
        repeat (2) @(negedge Clk);
        check_reset_outputs("reset");
        Reset = 1'b1;
        S_raw = 8'hA5;
        repeat (4) @(negedge Clk);

        // Clean press
        @(negedge Clk);
        Run_raw = 1'b0;
        k = cyc + 1;
        expect_press(1'b0, k, 8'hA5);
        while (cyc < k + D) @(negedge Clk);
        chk("clean_run_before_fall", Run, 1);
        @(negedge Clk);
        chk("clean_run_fall", Run, 0);
        chk("clean_run_press_high", Run_press, 1);
        @(negedge Clk);
        chk("clean_run_press_single", Run_press, 0);
        while (cyc < k + 19) @(negedge Clk);
        Run_raw = 1'b1;
        r = k + 20;
        while (cyc < r + D) @(negedge Clk);
        chk("clean_run_before_rise", Run, 0);
        @(negedge Clk);
        chk("clean_run_rise", Run, 1);
        chk("clean_run_count", Run_count, 8'h01);
        repeat (6) @(negedge Clk);

        // Snapshot on ClearA_LoadB press
        S_raw = 8'h07;
        repeat (4) @(negedge Clk);
        @(negedge Clk);
        ClearA_LoadB_raw = 1'b0;
        k = cyc + 1;
        expect_press(1'b1, k, 8'h07);
        while (cyc < k + 1 + D) @(negedge Clk);
        chk("snap_clr_level", ClearA_LoadB, 0);
        S_raw = 8'h3B;
        @(negedge Clk);
        chk("snap_s_before_sync", S, 8'h07);
        @(negedge Clk);
        chk("snap_s_synced", S, 8'h3B);
        chk("snap_s_snap_held", S_snap, 8'h07);
        chk("snap_run_count_cleared", Run_count, 8'h00);
        while (cyc < k + 11) @(negedge Clk);
        ClearA_LoadB_raw = 1'b1;
        repeat (D + 6) @(negedge Clk);
        chk("snap_clr_released", ClearA_LoadB, 1);

        // Bounce rejection
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            Run_raw = 1'b0;
            @(negedge Clk);
            @(negedge Clk);
            Run_raw = 1'b1;
        end
        @(negedge Clk);
        Run_raw = 1'b0;
        k = cyc + 1;
        expect_press(1'b0, k, 8'h3B);
        while (cyc < k + D) @(negedge Clk);
        chk("bounce_run_before_fall", Run, 1);
        while (cyc < k + 14) @(negedge Clk);
        Run_raw = 1'b1;
        repeat (D + 6) @(negedge Clk);
        chk("bounce_run_count", Run_count, 8'h01);

        // Interlock: Run ignored while ClearA_LoadB is held accepted
        @(negedge Clk);
        ClearA_LoadB_raw = 1'b0;
        k = cyc + 1;
        expect_press(1'b1, k, 8'h3B);
        while (cyc < k + 7) @(negedge Clk);
        chk("interlock_clr_level", ClearA_LoadB, 0);
        Run_raw = 1'b0;
        run_seen_low = 1'b0;
        repeat (12) begin
            @(negedge Clk);
            if (!Run) run_seen_low = 1'b1;
        end
        Run_raw = 1'b1;
        repeat (8) begin
            @(negedge Clk);
            if (!Run) run_seen_low = 1'b1;
        end
        chk("interlock_run_level", run_seen_low, 0);
        chk("interlock_run_count", Run_count, 8'h00);
        ClearA_LoadB_raw = 1'b1;
        repeat (D + 6) @(negedge Clk);

        // Collision: both keys low on the same edge
        @(negedge Clk);
        Run_raw          = 1'b0;
        ClearA_LoadB_raw = 1'b0;
        k = cyc + 1;
        expect_press(1'b1, k, 8'h3B);
        run_seen_low = 1'b0;
        repeat (12) begin
            @(negedge Clk);
            if (!Run) run_seen_low = 1'b1;
        end
        Run_raw          = 1'b1;
        ClearA_LoadB_raw = 1'b1;
        repeat (D + 6) begin
            @(negedge Clk);
            if (!Run) run_seen_low = 1'b1;
        end
        chk("collision_run_level", run_seen_low, 0);

        // Counter wrap and clear
        for (int i = 0; i < 257; i++) press_key(1'b0, 8, 1'b1, 8'h3B);
        chk("wrap_run_count", Run_count, 8'h01);
        press_key(1'b1, 8, 1'b1, 8'h3B);
        chk("wrap_cleared", Run_count, 8'h00);
        press_key(1'b0, 8, 1'b1, 8'h3B);
        chk("pre_reset_run_count", Run_count, 8'h01);

        // Reset during PRESS_WAIT
        @(negedge Clk);
        Run_raw = 1'b0;
        k = cyc + 1;
        while (cyc < k + 3) @(negedge Clk);
        #2 Reset = 1'b0;
        Run_raw = 1'b1;
        #1 check_reset_outputs("reset_press_wait");
        repeat (2) @(negedge Clk);
        #2 Reset = 1'b1;
        repeat (12) @(negedge Clk);
        chk("after_reset1_run", Run, 1);

        // Reset while PRESSED with the pulse in flight
        @(negedge Clk);
        Run_raw = 1'b0;
        k = cyc + 1;
        expect_press(1'b0, k, 8'h3B);
        while (cyc < k + 1 + D) @(negedge Clk);
        chk("pressed_run_press_high", Run_press, 1);
        #2 Reset = 1'b0;
        #1 check_reset_outputs("reset_pressed");
        Run_raw = 1'b1;
        repeat (2) @(negedge Clk);
        #2 Reset = 1'b1;
        repeat (12) @(negedge Clk);
        chk("after_reset2_run", Run, 1);
        chk("after_reset2_count", Run_count, 8'h00);

        chk("scoreboard_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
